// File: rtl/reg_wb_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
// Optional feature macro used by reg_wb_sched: REG_WB_PERF_EN.
package reg_wb_sched_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned NREG   = 32;
   localparam int unsigned PERF_W = 32;

   // Round-robin pointer encoding: which writeback source is preferred next
   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;

   // Writeback payload presented by either requester
   typedef struct packed {
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } wb_req_t;

   // Scoreboard hazard lookup: busy and not being written this cycle; x0 never hits
   function automatic logic sb_hit(input logic [NREG-1:0]   busy,
                                   input logic [ADDR_W-1:0] idx,
                                   input logic              wr_en,
                                   input logic [ADDR_W-1:0] wr_idx);
      sb_hit = (idx != '0) && busy[idx] && !(wr_en && (wr_idx == idx));
   endfunction

endpackage

// File: rtl/reg_wb_sched_scoreboard.sv
// Per-register busy scoreboard: set on issue, clear on register-file write,
// and three hazard lookups with same-cycle write bypass.
module reg_wb_sched_scoreboard
   import reg_wb_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_idx,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_idx,
   input  logic [ADDR_W-1:0] rs1_idx,
   input  logic [ADDR_W-1:0] rs2_idx,
   input  logic [ADDR_W-1:0] rd_idx,
   output logic              rs1_hit_c,
   output logic              rs2_hit_c,
   output logic              rd_hit_c,
   output logic              any_busy_c
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   // Next busy vector: clear first so a same-index set wins
   always_comb begin
      busy_nxt = busy;
      if (clr_en) begin
         busy_nxt[clr_idx] = 1'b0;
      end
      if (set_en && (set_idx != '0)) begin
         busy_nxt[set_idx] = 1'b1;
      end
   end

   // Busy vector register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Hazard lookups against the current busy state
   always_comb begin
      rs1_hit_c  = sb_hit(busy, rs1_idx, clr_en, clr_idx);
      rs2_hit_c  = sb_hit(busy, rs2_idx, clr_en, clr_idx);
      rd_hit_c   = sb_hit(busy, rd_idx,  clr_en, clr_idx);
      any_busy_c = |busy;
   end

endmodule

// File: rtl/reg_wb_sched.sv
// Register-file write-port scheduler: arbitrates ALU/LSU writebacks onto the
// single write port and stalls issue on RAW/WAW hazards.
// Optional: define REG_WB_PERF_EN to add stall/conflict performance counters.
module reg_wb_sched
   import reg_wb_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rs1,
   input  logic [ADDR_W-1:0] iss_rs2,
   input  logic              iss_rs1_en,
   input  logic              iss_rs2_en,
   input  logic [ADDR_W-1:0] iss_rd,
   input  logic              iss_rd_we,
   output logic              iss_stall,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_waddr,
   input  logic [DATA_W-1:0] alu_wdata,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_waddr,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              idle
`ifdef REG_WB_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_conflict_cnt
`endif
);

   wb_src_e rr_ptr;
   logic    gnt_alu;
   logic    gnt_lsu;
   logic    conflict;
   logic    hs;
   wb_req_t req_sel;
   logic    rs1_hit_c;
   logic    rs2_hit_c;
   logic    rd_hit_c;
   logic    any_busy_c;
   logic    iss_set_c;

   reg_wb_sched_scoreboard u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_en     (iss_set_c),
      .set_idx    (iss_rd),
      .clr_en     (rf_we),
      .clr_idx    (rf_waddr),
      .rs1_idx    (iss_rs1),
      .rs2_idx    (iss_rs2),
      .rd_idx     (iss_rd),
      .rs1_hit_c  (rs1_hit_c),
      .rs2_hit_c  (rs2_hit_c),
      .rd_hit_c   (rd_hit_c),
      .any_busy_c (any_busy_c)
   );

   // Issue hazard detection and scoreboard set request
   always_comb begin
      iss_stall = iss_valid & ((iss_rs1_en & rs1_hit_c) |
                               (iss_rs2_en & rs2_hit_c) |
                               (iss_rd_we  & rd_hit_c));
      iss_set_c = iss_valid & ~iss_stall & iss_rd_we;
      idle      = ~any_busy_c & ~rf_we;
   end

   // Writeback arbitration: lone requester wins, conflicts follow rr_ptr
   always_comb begin
      conflict      = alu_valid & lsu_valid;
      gnt_lsu       = lsu_valid & (~alu_valid | (rr_ptr == WB_SRC_LSU));
      gnt_alu       = alu_valid & ~gnt_lsu;
      hs            = gnt_alu | gnt_lsu;
      req_sel.waddr = gnt_lsu ? lsu_waddr : alu_waddr;
      req_sel.wdata = gnt_lsu ? lsu_wdata : alu_wdata;
      alu_ready     = gnt_alu;
      lsu_ready     = gnt_lsu;
   end

   // Round-robin pointer moves to the loser only on a conflict
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= WB_SRC_ALU;
      end else if (conflict) begin
         rr_ptr <= gnt_alu ? WB_SRC_LSU : WB_SRC_ALU;
      end
   end

   // Write-port register; writes to x0 are accepted but dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= hs && (req_sel.waddr != '0);
         if (hs && (req_sel.waddr != '0)) begin
            rf_waddr <= req_sel.waddr;
            rf_wdata <= req_sel.wdata;
         end
      end
   end

`ifdef REG_WB_PERF_EN
   // Saturating performance counters for stall and arbitration-conflict cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt    <= '0;
         perf_conflict_cnt <= '0;
      end else begin
         if (iss_stall && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
         end
         if (conflict && (perf_conflict_cnt != '1)) begin
            perf_conflict_cnt <= perf_conflict_cnt + PERF_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_reg_wb_sched.sv
// Randomized scoreboard bench for reg_wb_sched with a behavioural reference model.
`timescale 1ns/1ps
module tb_reg_wb_sched;
   import reg_wb_sched_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              iss_valid = 1'b0;
   logic [ADDR_W-1:0] iss_rs1 = '0;
   logic [ADDR_W-1:0] iss_rs2 = '0;
   logic              iss_rs1_en = 1'b0;
   logic              iss_rs2_en = 1'b0;
   logic [ADDR_W-1:0] iss_rd = '0;
   logic              iss_rd_we = 1'b0;
   logic              iss_stall;
   logic              alu_valid = 1'b0;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_waddr = '0;
   logic [DATA_W-1:0] alu_wdata = '0;
   logic              lsu_valid = 1'b0;
   logic              lsu_ready;
   logic [ADDR_W-1:0] lsu_waddr = '0;
   logic [DATA_W-1:0] lsu_wdata = '0;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              idle;
`ifdef REG_WB_PERF_EN
   logic [31:0]       perf_stall_cnt;
   logic [31:0]       perf_conflict_cnt;
`endif

   reg_wb_sched dut (
      .clk(clk), .rst_n(rst_n),
      .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en),
      .iss_rd(iss_rd), .iss_rd_we(iss_rd_we), .iss_stall(iss_stall),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .idle(idle)
`ifdef REG_WB_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model state
   typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } exp_t;
   exp_t              expq[$];
   bit                mbusy[NREG];
   bit                m_we;            // a write is landing on the port this cycle
   logic [ADDR_W-1:0] m_waddr;
   bit                prefer_lsu;      // source that lost the last conflict
   int unsigned       m_stall_cnt, m_conf_cnt;
   // Requester-side bookkeeping (requests held until accepted)
   bit                a_v, l_v;
   logic [ADDR_W-1:0] a_addr, l_addr;
   logic [DATA_W-1:0] a_data, l_data;
   bit                iss_hold;

   function automatic bit model_idle();
      for (int r = 0; r < NREG; r++) if (mbusy[r]) return 1'b0;
      return !m_we;
   endfunction

   function automatic bit mhit(input logic [ADDR_W-1:0] r);
      return (r != '0) && mbusy[r] && !(m_we && m_waddr == r);
   endfunction

   // Choose a busy register nobody is writing yet; optionally fall back to x0
   function automatic bit pick(input logic [ADDR_W-1:0] other, input bit other_v,
                               input bit allow_zero, output logic [ADDR_W-1:0] tgt);
      int cand[$];
      for (int r = 1; r < NREG; r++)
         if (mbusy[r] && !(m_we && m_waddr == ADDR_W'(r)) && !(other_v && other == ADDR_W'(r)))
            cand.push_back(r);
      if (cand.size() > 0 && (!allow_zero || $urandom_range(0, 9) < 8)) begin
         tgt = ADDR_W'(cand[$urandom_range(0, cand.size() - 1)]);
         return 1'b1;
      end
      tgt = '0;
      return allow_zero;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
      m_we = 1'b0; m_waddr = '0; prefer_lsu = 1'b0;
      m_stall_cnt = 0; m_conf_cnt = 0;
      a_v = 1'b0; l_v = 1'b0; iss_hold = 1'b0;
      expq.delete();
   endtask

   task automatic drive_idle();
      iss_valid = 1'b0; iss_rs1_en = 1'b0; iss_rs2_en = 1'b0; iss_rd_we = 1'b0;
      alu_valid = 1'b0; lsu_valid = 1'b0;
   endtask

   // Async reset pulse with checks while held low
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_clear();
      drive_idle();
      iss_valid = 1'b1; iss_rs1_en = 1'b1; iss_rs2_en = 1'b1; iss_rd_we = 1'b1;
      iss_rs1 = 5'd1; iss_rs2 = 5'd2; iss_rd = 5'd3;
      #1;
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_stall", 64'(iss_stall), 64'd0);
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
`ifdef REG_WB_PERF_EN
      chk("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
      chk("rst_perf_conflict", 64'(perf_conflict_cnt), 64'd0);
`endif
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
   endtask

   // One clock cycle of randomized stimulus plus model prediction
   task automatic step(input bit new_work);
      logic [ADDR_W-1:0] t;
      bit exp_stall, g_alu, g_lsu, conflict, hs, ok;
      logic [ADDR_W-1:0] hs_addr;
      logic [DATA_W-1:0] hs_data;
      @(negedge clk);
      if (!a_v && $urandom_range(0, 9) < 5) begin
         ok = pick(l_addr, l_v, new_work, t);
         if (ok) begin a_v = 1'b1; a_addr = t; a_data = {$urandom, $urandom}; end
      end
      if (!l_v && $urandom_range(0, 9) < 5) begin
         ok = pick(a_addr, a_v, new_work, t);
         if (ok) begin l_v = 1'b1; l_addr = t; l_data = {$urandom, $urandom}; end
      end
      if (!iss_hold) begin
         iss_valid  = new_work && ($urandom_range(0, 9) < 7);
         iss_rs1    = ADDR_W'($urandom_range(0, 7));
         iss_rs2    = ADDR_W'($urandom_range(0, 7));
         iss_rd     = ADDR_W'($urandom_range(0, 7));
         iss_rs1_en = 1'($urandom_range(0, 1));
         iss_rs2_en = 1'($urandom_range(0, 1));
         iss_rd_we  = ($urandom_range(0, 9) < 6);
      end
      alu_valid = a_v; alu_waddr = a_addr; alu_wdata = a_data;
      lsu_valid = l_v; lsu_waddr = l_addr; lsu_wdata = l_data;
      #1;
      exp_stall = iss_valid && ((iss_rs1_en && mhit(iss_rs1)) ||
                                (iss_rs2_en && mhit(iss_rs2)) ||
                                (iss_rd_we && mhit(iss_rd)));
      conflict = a_v && l_v;
      if (conflict) begin g_lsu = prefer_lsu; g_alu = !prefer_lsu; end
      else begin g_alu = a_v; g_lsu = l_v; end
      chk("iss_stall", 64'(iss_stall), 64'(exp_stall));
      chk("alu_ready", 64'(alu_ready), 64'(g_alu));
      chk("lsu_ready", 64'(lsu_ready), 64'(g_lsu));
      chk("idle", 64'(idle), 64'(model_idle()));
      // Advance the model to the next edge
      if (exp_stall) m_stall_cnt++;
      if (conflict) begin m_conf_cnt++; prefer_lsu = g_alu; end
      hs = g_alu || g_lsu;
      hs_addr = g_lsu ? l_addr : a_addr;
      hs_data = g_lsu ? l_data : a_data;
      if (m_we) mbusy[m_waddr] = 1'b0;
      if (iss_valid && !exp_stall && iss_rd_we && iss_rd != '0) mbusy[iss_rd] = 1'b1;
      m_we = hs && hs_addr != '0;
      if (m_we) begin
         m_waddr = hs_addr;
         expq.push_back('{a: hs_addr, d: hs_data});
      end
      if (g_alu) a_v = 1'b0;
      if (g_lsu) l_v = 1'b0;
      iss_hold = exp_stall;
   endtask

   // Monitor: every register-file write must match the next expected write
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rf_we === 1'b1) begin
            if (expq.size() == 0) chk("unexpected_rf_write", 64'(rf_waddr), 64'hFFFF);
            else begin
               e = expq.pop_front();
               chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
               chk("rf_wdata", rf_wdata, e.d);
            end
         end
      end
   end

   initial begin
      int n;
      model_clear();
      do_reset();
      for (int c = 0; c < 1500; c++) step(1'b1);
      do_reset();
      for (int c = 0; c < 1500; c++) step(1'b1);
      // Drain: no new issues or x0 writes, finish pending writebacks
      n = 0;
      while ((!model_idle() || a_v || l_v || iss_hold) && n < 300) begin
         step(1'b0);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 64'(n), 64'd0);
      @(negedge clk);
      drive_idle();
      #1;
      chk("final_idle", 64'(idle), 64'd1);
      chk("final_queue_empty", 64'(expq.size()), 64'd0);
`ifdef REG_WB_PERF_EN
      chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall_cnt));
      chk("perf_conflict_cnt", 64'(perf_conflict_cnt), 64'(m_conf_cnt));
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Controls the single write port of the NPC register file and tracks pending writes with a per-register busy scoreboard.
- Arbitrates two writeback requesters (ALU result path, LSU load path) onto the register-file write port with valid/ready handshakes.
- Tells issue/decode to stall on RAW and WAW hazards against in-flight destinations.
- Sits between decode/issue, the execute/LSU writeback paths, and REG_files' we/waddr/wdata inputs.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 64, register data width.
- NREG, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- iss_valid  in  1  decode presents an instruction
- iss_rs1  in  ADDR_W  source 1 index
- iss_rs2  in  ADDR_W  source 2 index
- iss_rs1_en  in  1  rs1 is read
- iss_rs2_en  in  1  rs2 is read
- iss_rd  in  ADDR_W  destination index
- iss_rd_we  in  1  instruction writes rd
- iss_stall  out  1  issue must hold this cycle
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted
- alu_waddr  in  ADDR_W  ALU destination
- alu_wdata  in  DATA_W  ALU data
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request accepted
- lsu_waddr  in  ADDR_W  LSU destination
- lsu_wdata  in  DATA_W  LSU data
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- idle  out  1  no busy bits set and rf_we low

Behaviour:
- Reset (rst_n low, async): busy[NREG-1:0]=0, rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0 (ALU preferred). Immediately after reset, idle=1 and iss_stall=0.
- Scoreboard, hit term: hit(r) = busy[r] & ~(rf_we & rf_waddr==r). The write port bypasses wdata to a same-cycle read, so a register being written this cycle is not a hazard.
- Stall:
  - iss_stall = iss_valid & ((iss_rs1_en & hit(rs1)) | (iss_rs2_en & hit(rs2)) | (iss_rd_we & hit(rd))).
  - Index 0 never hits.
  - Combinational.
- Issue: iss_valid & ~iss_stall & iss_rd_we & rd!=0 sets busy[rd] at the next edge.
- Clear: rf_we=1 clears busy[rf_waddr] at the edge.
- Same index set and cleared in one cycle: set wins, so busy stays 1.
- Arbitration:
  - Combinational grant.
  - Only one valid: that source is granted.
  - Both valid: rr_ptr picks the winner (0=ALU, 1=LSU).
  - rr_ptr updates only on a conflict cycle and points at the loser, so neither source starves (max wait 1 cycle).
  - ready = grant; the output register always accepts. A handshake is valid & ready.
  - Requesters hold valid, addr and data stable until ready.
- Write port:
  - Registered, 1-cycle latency.
  - On handshake with waddr!=0: rf_we=1, rf_waddr/rf_wdata = granted source's values at the next edge.
  - Handshake with waddr==0: accepted, rf_we=0 (write dropped).
  - No handshake: rf_we=0. rf_waddr/rf_wdata keep their last value.
- Writeback to a non-busy register: write is still performed; the clear is a no-op. A bench assertion flags this.
- idle = ~|busy & ~rf_we.
- Reset mid-operation: all pending busy bits are lost. Upstream flushes in-flight requests on the same reset.

Optional Feature:
- Macro: REG_WB_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] (cycles with iss_stall=1) and perf_conflict_cnt[31:0] (cycles with both sources valid).
  - Both reset to 0.
  - Both saturate at 0xFFFF_FFFF.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared defines.v gains:
  - RegAddrBus, RegBus, RegNum, WriteEnable already present.
  - New WbSrcAlu=1'b0 and WbSrcLsu=1'b1 for rr_ptr.
- One natural sub-module: reg_scoreboard.
  - Holds the busy vector, set/clear logic and the three hit lookups.
  - reg_wb_sched keeps the arbiter and the output register.

Test Plan:
- Reset released, no requests -> idle=1, rf_we=0, iss_stall=0, all busy=0.
- Issue rd=5; next cycle issue rs1=5 -> iss_stall=1. Then ALU writes x5 with 0x1234 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 one cycle after the handshake. In that same cycle iss_stall=0 (bypass) and busy[5] clears.
- ALU (x3, 0xAA) and LSU (x4, 0xBB) valid together for 2 requests each:
  - Grant order is ALU, LSU, ALU, LSU.
  - rf writes appear on consecutive cycles.
  - Each ready is held low on the loser's cycle.
- Issue rd=0 with iss_rd_we=1, then LSU writes x0 -> busy unchanged, lsu_ready=1, rf_we stays 0.
- Issue rd=7 in the same cycle rf_we clears x7 -> busy[7]=1 afterward. A further rs2=7 read stalls until the next x7 write.
- REG_WB_PERF_EN defined, 3 stall cycles and 2 conflict cycles -> perf_stall_cnt=3, perf_conflict_cnt=2. rst_n pulse mid-test -> both 0, all busy 0 asynchronously.
